comparator_case_sync: RTL and testbench
=======================================

Name: comparator_case_sync

Overview:
- Registered magnitude comparator between the upper and lower halves of one packed input vector `a`.
- Produces a one-hot 3-bit relation code: greater, equal, less.
- Used as a small status/decision primitive inside datapath control logic.
- Has one clock domain, one pipeline stage, and an explicit valid qualifier.

Parameters:
- WIDTH, default 1: width of each operand. `a` carries two operands of WIDTH bits each. WIDTH must be at least 1.
- SIGNED, default 0: 0 compares as unsigned; 1 compares as two's complement.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies `a` in the current cycle.
- a  input  2*WIDTH  packed operands.
  - Operand A = a[2*WIDTH-1:WIDTH].
  - Operand B = a[WIDTH-1:0].
  - For WIDTH=1: A=a[1], B=a[0].
- out_valid  output  1  high when y holds a fresh result.
- y  output  3, declared ascending [0:2]  one-hot relation code.
  - y[0] = A>B.
  - y[1] = A==B.
  - y[2] = A<B.

Behaviour:
- Reset:
  - rst_n low clears out_valid to 0 and y to 3'b000, immediately, without waiting for a clock edge.
  - The reset is asynchronous assert and synchronous-safe deassert (internal flops only; no reset synchronizer inside this block).
- Latency is 1 cycle.
  - On a rising clk edge with in_valid=1, y is loaded with the relation of the A/B values sampled at that edge, and out_valid is set to 1.
  - On an edge with in_valid=0, out_valid goes to 0 and y holds its previous value. There are no spurious updates.
- Result encoding:
  - The relation is selected by a case decode over {A>B, A==B}.
  - Exactly one bit of y is set whenever out_valid=1.
  - The legal codes are 100 (GT), 010 (EQ) and 001 (LT).
  - The 000 code appears only after reset, before the first valid sample.
- Arithmetic:
  - SIGNED=0: operands are zero-extended.
  - SIGNED=1: the MSB of each operand is the sign bit. For example, with WIDTH=2, A=2'b10 (-2) is less than B=2'b01 (+1).
  - No overflow is possible; the comparison is full width.
- Back-to-back: in_valid may be held high every cycle. The block accepts one sample per cycle, with no stall and no backpressure.
- Reset mid-operation: a result in flight is discarded, and out_valid=0 on the first edge after reset release unless in_valid=1 at that edge.
- X/Z on `a` while in_valid=1: the output is undefined. This is not checked.

Decomposition:
- Shared package `comparator_case_pkg`:
  - Localparams CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000, all written in [0:2] order.
  - A `cmp_code_t` 3-bit typedef.
- Sub-module `comparator_case_core`:
  - Purely combinational, parameterized WIDTH and SIGNED.
  - Takes A and B, produces a `cmp_code_t` via a case statement.
  - Instantiated once; the top level adds the valid register and the result register.

Test Plan:
- Reset: hold rst_n=0, toggle clk -> y=000, out_valid=0. Assert rst_n low asynchronously mid-cycle -> both outputs clear without a clk edge.
- WIDTH=1 exhaustive, one value per cycle with in_valid=1 -> results one cycle later:
  - a=00 -> y=010
  - a=01 -> y=001
  - a=10 -> y=100
  - a=11 -> y=010
  - out_valid=1 for each.
- Valid gating: a=10 with in_valid=1, then a=01 with in_valid=0 -> y stays 100 and out_valid drops to 0 on the second edge.
- SIGNED=1, WIDTH=4:
  - a={4'hF, 4'h1} (-1 vs 1) -> y=001.
  - a={4'h7, 4'h8} (7 vs -8) -> y=100.
  - The same vectors with SIGNED=0 -> y=100, then 001.
- Back-to-back, WIDTH=8: a={8'd5,8'd5}, then {8'd200,8'd3}, then {8'd0,8'd255} on consecutive cycles -> y=010, 100, 001 on consecutive cycles, with out_valid held at 1.
- Reset mid-stream: assert rst_n low while out_valid=1 -> y=000 and out_valid=0 at once. Release with in_valid=0 -> outputs stay cleared.

Source files
------------

// File: rtl/comparator_case_pkg.sv
// -----------------------------------------------------------------------------
// comparator_case_pkg
//   Shared definitions for the registered case-decoded magnitude comparator.
//   Relation codes are written in [0:2] order: bit 0 = GT, bit 1 = EQ,
//   bit 2 = LT, so a literal 3'b100 lands in index 0 of a [0:2] vector.
// -----------------------------------------------------------------------------
package comparator_case_pkg;

    typedef logic [0:2] cmp_code_t;

    localparam cmp_code_t CMP_GT   = 3'b100;
    localparam cmp_code_t CMP_EQ   = 3'b010;
    localparam cmp_code_t CMP_LT   = 3'b001;
    localparam cmp_code_t CMP_NONE = 3'b000;

endpackage : comparator_case_pkg

// File: rtl/comparator_case_core.sv
// -----------------------------------------------------------------------------
// comparator_case_core
//   Purely combinational magnitude comparator producing a one-hot relation
//   code through a case decode over {A>B, A==B}.
//
//   Ports:
//     op_a  [WIDTH-1:0]  operand A
//     op_b  [WIDTH-1:0]  operand B
//     code  cmp_code_t   one-hot relation (GT / EQ / LT)
//
//   Parameters:
//     WIDTH   operand width (>= 1)
//     SIGNED  0: unsigned compare, 1: two's complement compare
// -----------------------------------------------------------------------------
module comparator_case_core
    import comparator_case_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output cmp_code_t        code
);

    // Both operands are widened by one bit and compared as signed values.
    // Zero-extension makes the signed compare behave as unsigned; sign
    // extension gives the two's complement ordering. One extra bit is enough
    // that no overflow can occur.
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] b_ext;
    logic                  a_gt_b;
    logic                  a_eq_b;

    always_comb begin
        a_ext = SIGNED ? {op_a[WIDTH-1], op_a} : {1'b0, op_a};
        b_ext = SIGNED ? {op_b[WIDTH-1], op_b} : {1'b0, op_b};
    end

    assign a_gt_b = (a_ext > b_ext);
    assign a_eq_b = (a_ext == b_ext);

    always_comb begin
        code = CMP_NONE;
        case ({a_gt_b, a_eq_b})
            2'b10:   code = CMP_GT;
            2'b01:   code = CMP_EQ;
            2'b00:   code = CMP_LT;
            // {1,1} cannot occur; keep the idle code for completeness.
            default: code = CMP_NONE;
        endcase
    end

endmodule : comparator_case_core

// File: rtl/comparator_case_sync.sv
// -----------------------------------------------------------------------------
// comparator_case_sync
//   Registered comparator between the upper and lower halves of `a`.
//   One pipeline stage, one clock domain, explicit valid qualifier.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (clears out_valid and y)
//     in_valid   qualifies `a` this cycle
//     a          [2*WIDTH-1:0] packed operands, A = upper half, B = lower half
//     out_valid  y holds a result sampled on the previous edge
//     y          [0:2] one-hot relation: y[0]=A>B, y[1]=A==B, y[2]=A<B
//
//   Valid semantics: there is no ready/backpressure. Every edge with
//   in_valid=1 is an accepted sample; its result appears on y with
//   out_valid=1 one cycle later. Edges with in_valid=0 drop out_valid and
//   leave y holding the last result. y reads 000 only between reset and the
//   first accepted sample.
// -----------------------------------------------------------------------------
module comparator_case_sync
    import comparator_case_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter bit SIGNED = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] a,
    output logic               out_valid,
    output logic [0:2]         y
);

    cmp_code_t code;

    comparator_case_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .op_a (a[2*WIDTH-1:WIDTH]),
        .op_b (a[WIDTH-1:0]),
        .code (code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= CMP_NONE;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= code;
            end
        end
    end

endmodule : comparator_case_sync

// File: tb/tb_comparator_case_sync.sv
// -----------------------------------------------------------------------------
// tb_comparator_case_sync
//   Directed bench for comparator_case_sync. Four instances cover the
//   parameterisations of interest (WIDTH=1 unsigned, WIDTH=4 signed and
//   unsigned, WIDTH=8 unsigned); they share clock, reset and in_valid.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_comparator_case_sync;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;

    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    logic [1:0]  a_w1;
    logic [7:0]  a_s4;
    logic [7:0]  a_u4;
    logic [15:0] a_w8;

    logic       ov_w1, ov_s4, ov_u4, ov_w8;
    logic [0:2] y_w1, y_s4, y_u4, y_w8;

    comparator_case_sync #(.WIDTH(1), .SIGNED(1'b0)) u_w1 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
        .a (a_w1), .out_valid (ov_w1), .y (y_w1)
    );

    comparator_case_sync #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
        .a (a_s4), .out_valid (ov_s4), .y (y_s4)
    );

    comparator_case_sync #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
        .a (a_u4), .out_valid (ov_u4), .y (y_u4)
    );

    comparator_case_sync #(.WIDTH(8), .SIGNED(1'b0)) u_w8 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
        .a (a_w8), .out_valid (ov_w8), .y (y_w8)
    );

    // ---------------- counters ----------------
    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- check helpers ----------------
    task automatic check_y(input string tag, input logic [0:2] obs, input logic [0:2] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed y=%b expected y=%b", tag, obs, exp);
        end
    endtask

    task automatic check_v(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed out_valid=%b expected out_valid=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; outputs are sampled there
    // and new inputs are driven there, well clear of the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_w1     = '0;
        a_s4     = '0;
        a_u4     = '0;
        a_w8     = '0;

        // Reset held across clock edges.
        tick();
        tick();
        check_y("rst_y_w1", y_w1, 3'b000);
        check_v("rst_v_w1", ov_w1, 1'b0);
        check_y("rst_y_w8", y_w8, 3'b000);
        check_v("rst_v_s4", ov_s4, 1'b0);

        rst_n = 1'b1;
        tick();
        check_v("post_rst_idle_v", ov_w1, 1'b0);
        check_y("post_rst_idle_y", y_w1, 3'b000);

        // WIDTH=1 exhaustive, back-to-back.
        in_valid = 1'b1;
        a_w1 = 2'b00; tick();
        check_y("w1_00_y", y_w1, 3'b010); check_v("w1_00_v", ov_w1, 1'b1);
        a_w1 = 2'b01; tick();
        check_y("w1_01_y", y_w1, 3'b001); check_v("w1_01_v", ov_w1, 1'b1);
        a_w1 = 2'b10; tick();
        check_y("w1_10_y", y_w1, 3'b100); check_v("w1_10_v", ov_w1, 1'b1);
        a_w1 = 2'b11; tick();
        check_y("w1_11_y", y_w1, 3'b010); check_v("w1_11_v", ov_w1, 1'b1);

        // Valid gating: second sample is not qualified, y must hold.
        a_w1 = 2'b10; in_valid = 1'b1; tick();
        check_y("gate_load_y", y_w1, 3'b100); check_v("gate_load_v", ov_w1, 1'b1);
        a_w1 = 2'b01; in_valid = 1'b0; tick();
        check_y("gate_hold_y", y_w1, 3'b100); check_v("gate_hold_v", ov_w1, 1'b0);
        tick();
        check_y("gate_hold2_y", y_w1, 3'b100); check_v("gate_hold2_v", ov_w1, 1'b0);

        // Signed vs unsigned, WIDTH=4.
        in_valid = 1'b1;
        a_s4 = {4'hF, 4'h1}; a_u4 = {4'hF, 4'h1}; tick();
        check_y("s4_m1_vs_1", y_s4, 3'b001);
        check_y("u4_15_vs_1", y_u4, 3'b100);
        a_s4 = {4'h7, 4'h8}; a_u4 = {4'h7, 4'h8}; tick();
        check_y("s4_7_vs_m8", y_s4, 3'b100);
        check_y("u4_7_vs_8", y_u4, 3'b001);
        a_s4 = {4'h8, 4'h8}; a_u4 = {4'h0, 4'hF}; tick();
        check_y("s4_m8_eq", y_s4, 3'b010);
        check_y("u4_0_vs_15", y_u4, 3'b001);

        // Back-to-back, WIDTH=8.
        a_w8 = {8'd5, 8'd5}; tick();
        check_y("w8_5_5_y", y_w8, 3'b010); check_v("w8_5_5_v", ov_w8, 1'b1);
        a_w8 = {8'd200, 8'd3}; tick();
        check_y("w8_200_3_y", y_w8, 3'b100); check_v("w8_200_3_v", ov_w8, 1'b1);
        a_w8 = {8'd0, 8'd255}; tick();
        check_y("w8_0_255_y", y_w8, 3'b001); check_v("w8_0_255_v", ov_w8, 1'b1);

        // Reset mid-stream: assert asynchronously while clk is high, no edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_y("async_rst_y_w8", y_w8, 3'b000);
        check_v("async_rst_v_w8", ov_w8, 1'b0);
        check_y("async_rst_y_s4", y_s4, 3'b000);
        check_v("async_rst_v_w1", ov_w1, 1'b0);

        // Release with in_valid=0: outputs stay cleared.
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_y("release_idle_y", y_w8, 3'b000);
        check_v("release_idle_v", ov_w8, 1'b0);

        // First qualified sample after release.
        in_valid = 1'b1;
        a_w8 = {8'd9, 8'd9}; tick();
        check_y("after_rel_y", y_w8, 3'b010); check_v("after_rel_v", ov_w8, 1'b1);
        in_valid = 1'b0; tick();
        check_v("after_rel_drop_v", ov_w8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_comparator_case_sync
